// File: rtl/mult_row_pipe_if.sv
// Handshake bundle for mult_row_pipe: input beat (operands + per-beat mode flags)
// and the result channel. Parameters must match the attached mult_row_pipe.
interface mult_row_pipe_if #(
    parameter int DATA_WIDTH   = 8,
    parameter int NUM_MACS     = 4,
    parameter int NUM_ATTN_PES = 4,
    parameter int ACC_WIDTH    = 24
);
    localparam int L = NUM_MACS * NUM_ATTN_PES;

    logic                    in_valid;
    logic                    in_ready;
    logic [L*DATA_WIDTH-1:0] a;
    logic [L*DATA_WIDTH-1:0] b;
    logic                    is_signed;
    logic                    acc_en;
    logic                    in_last;
    logic                    out_valid;
    logic                    out_ready;
    logic [L*ACC_WIDTH-1:0]  out;
    logic                    out_sat;

    modport master (
        output in_valid, a, b, is_signed, acc_en, in_last, out_ready,
        input  in_ready, out_valid, out, out_sat
    );

    modport slave (
        input  in_valid, a, b, is_signed, acc_en, in_last, out_ready,
        output in_ready, out_valid, out, out_sat
    );
endinterface

// File: rtl/mult_row_pipe.sv
// mult_row_pipe: pipelined element-wise multiply row with optional per-lane accumulation.
// Define MULT_ROW_PIPE_SAT_EN for saturating adds and out_sat; default build wraps.

module mult_row_lane #(
    parameter int DATA_WIDTH  = 8,
    parameter int ACC_WIDTH   = 24,
    parameter int PIPE_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  adv,
    input  logic [DATA_WIDTH-1:0] a,
    input  logic [DATA_WIDTH-1:0] b,
    input  logic                  is_signed,
    input  logic                  fin_vld,
    input  logic                  fin_acc,
    input  logic                  fin_last,
`ifdef MULT_ROW_PIPE_SAT_EN
    input  logic                  fin_signed,
`endif
    output logic [ACC_WIDTH-1:0]  res,
    output logic                  sat
);
    logic signed [2*DATA_WIDTH-1:0]        prod_s;
    logic        [2*DATA_WIDTH-1:0]        prod_u;
    logic        [ACC_WIDTH-1:0]           prod_ext;
    logic [PIPE_STAGES-1:0][ACC_WIDTH-1:0] prod_pipe;
    logic        [ACC_WIDTH-1:0]           acc;
    logic        [ACC_WIDTH-1:0]           p;
    logic        [ACC_WIDTH-1:0]           sum;
    logic                                  load;

    // Extension is resolved at capture so later stages carry a plain ACC_WIDTH value.
    assign prod_s   = $signed(a) * $signed(b);
    assign prod_u   = a * b;
    assign prod_ext = is_signed ? ACC_WIDTH'(prod_s) : ACC_WIDTH'(prod_u);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prod_pipe <= '0;
        end else if (adv) begin
            prod_pipe[0] <= prod_ext;
            for (int s = 1; s < PIPE_STAGES; s++) prod_pipe[s] <= prod_pipe[s-1];
        end
    end

    assign p    = prod_pipe[PIPE_STAGES-1];
    assign load = adv && fin_vld;

`ifdef MULT_ROW_PIPE_SAT_EN
    logic [ACC_WIDTH:0] sum_x;
    logic               ovf;
    logic               sat_grp;

    // The running sum is reinterpreted in the current beat's mode, so mixed groups clamp per beat.
    always_comb begin
        sum_x = fin_signed ? ({acc[ACC_WIDTH-1], acc} + {p[ACC_WIDTH-1], p})
                           : ({1'b0, acc} + {1'b0, p});
        ovf   = fin_signed ? (sum_x[ACC_WIDTH] ^ sum_x[ACC_WIDTH-1]) : sum_x[ACC_WIDTH];
        sum   = sum_x[ACC_WIDTH-1:0];
        if (ovf) begin
            if (fin_signed) sum = {sum_x[ACC_WIDTH], {(ACC_WIDTH-1){~sum_x[ACC_WIDTH]}}};
            else            sum = '1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc     <= '0;
            res     <= '0;
            sat     <= 1'b0;
            sat_grp <= 1'b0;
        end else if (load) begin
            if (!fin_acc) begin
                res <= p;
                sat <= 1'b0;
            end else if (!fin_last) begin
                acc     <= sum;
                sat_grp <= sat_grp | ovf;
            end else begin
                res     <= sum;
                sat     <= sat_grp | ovf;
                acc     <= '0;
                sat_grp <= 1'b0;
            end
        end
    end
`else
    assign sum = acc + p;
    assign sat = 1'b0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc <= '0;
            res <= '0;
        end else if (load) begin
            if (!fin_acc) begin
                res <= p;
            end else if (!fin_last) begin
                acc <= sum;
            end else begin
                res <= sum;
                acc <= '0;
            end
        end
    end
`endif
endmodule

module mult_row_pipe #(
    parameter int DATA_WIDTH   = 8,
    parameter int NUM_MACS     = 4,
    parameter int NUM_ATTN_PES = 4,
    parameter int PIPE_STAGES  = 2,
    parameter int ACC_WIDTH    = 24
) (
    input  logic          clk,
    input  logic          rst_n,
    mult_row_pipe_if.slave bus
);
    localparam int L = NUM_MACS * NUM_ATTN_PES;

    typedef struct packed {
`ifdef MULT_ROW_PIPE_SAT_EN
        logic is_signed;
`endif
        logic acc_en;
        logic in_last;
    } ctl_t;

    // vld_pipe[PIPE_STAGES-1:0] are the beat stages; vld_pipe[PIPE_STAGES] is out_valid.
    logic [PIPE_STAGES:0]          vld_pipe;
    ctl_t [PIPE_STAGES-1:0]        ctl_pipe;
    ctl_t                          ctl_in;
    ctl_t                          fin;
    logic                          fin_vld;
    logic                          adv;
    logic [L-1:0][ACC_WIDTH-1:0]   lane_res;
    logic [L-1:0]                  lane_sat;

    assign adv          = !vld_pipe[PIPE_STAGES] || bus.out_ready;
    assign bus.in_ready = adv;
    assign fin_vld      = vld_pipe[PIPE_STAGES-1];
    assign fin          = ctl_pipe[PIPE_STAGES-1];

    always_comb begin
        ctl_in         = '0;
`ifdef MULT_ROW_PIPE_SAT_EN
        ctl_in.is_signed = bus.is_signed;
`endif
        ctl_in.acc_en  = bus.acc_en;
        ctl_in.in_last = bus.acc_en && bus.in_last;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_pipe <= '0;
            ctl_pipe <= '0;
        end else if (adv) begin
            vld_pipe[0] <= bus.in_valid;
            ctl_pipe[0] <= ctl_in;
            for (int s = 1; s < PIPE_STAGES; s++) begin
                vld_pipe[s] <= vld_pipe[s-1];
                ctl_pipe[s] <= ctl_pipe[s-1];
            end
            // Mid-group beats fold into acc without presenting a result.
            vld_pipe[PIPE_STAGES] <= fin_vld && (!fin.acc_en || fin.in_last);
        end
    end

    for (genvar k = 0; k < L; k++) begin : g_lane
        mult_row_lane #(
            .DATA_WIDTH  (DATA_WIDTH),
            .ACC_WIDTH   (ACC_WIDTH),
            .PIPE_STAGES (PIPE_STAGES)
        ) u_lane (
            .clk        (clk),
            .rst_n      (rst_n),
            .adv        (adv),
            .a          (bus.a[k*DATA_WIDTH +: DATA_WIDTH]),
            .b          (bus.b[k*DATA_WIDTH +: DATA_WIDTH]),
            .is_signed  (bus.is_signed),
            .fin_vld    (fin_vld),
            .fin_acc    (fin.acc_en),
            .fin_last   (fin.in_last),
`ifdef MULT_ROW_PIPE_SAT_EN
            .fin_signed (fin.is_signed),
`endif
            .res        (lane_res[k]),
            .sat        (lane_sat[k])
        );
    end

    assign bus.out_valid = vld_pipe[PIPE_STAGES];
    assign bus.out       = lane_res;
    assign bus.out_sat   = |lane_sat;
endmodule

// File: tb/tb_mult_row_pipe.sv
// Bench for mult_row_pipe: random and directed beats scored against an arithmetic model;
// a second 16-bit-accumulator instance covers the overflow group.
`timescale 1ns/1ps
module tb_mult_row_pipe;
    localparam int DW = 8, NM = 4, NP = 4, L = NM * NP, PS = 2, AW = 24, AW2 = 16;
    localparam longint MASK = (longint'(1) << AW) - 1;
    localparam longint HALF = longint'(1) << (AW - 1);

    logic clk, rst_n;

    mult_row_pipe_if #(.DATA_WIDTH(DW), .NUM_MACS(NM), .NUM_ATTN_PES(NP), .ACC_WIDTH(AW))  bus ();
    mult_row_pipe_if #(.DATA_WIDTH(DW), .NUM_MACS(NM), .NUM_ATTN_PES(NP), .ACC_WIDTH(AW2)) bus2 ();

    mult_row_pipe #(.DATA_WIDTH(DW), .NUM_MACS(NM), .NUM_ATTN_PES(NP), .PIPE_STAGES(PS), .ACC_WIDTH(AW))
        dut (.clk(clk), .rst_n(rst_n), .bus(bus));
    mult_row_pipe #(.DATA_WIDTH(DW), .NUM_MACS(NM), .NUM_ATTN_PES(NP), .PIPE_STAGES(PS), .ACC_WIDTH(AW2))
        dut2 (.clk(clk), .rst_n(rst_n), .bus(bus2));

    typedef struct { logic [L*AW-1:0] val; logic sat; } res_t;

    int     n_chk = 0, n_pass = 0, n_out = 0;
    res_t   exp_q[$];
    res_t   mon_e;
    longint macc[L];
    bit     gsat;
    bit     rand_rdy;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [511:0] got, input logic [511:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Model: whole-number products, group sums, then reduce to ACC_WIDTH (wrap or clamp).
    function automatic void model_accept(input logic [L*DW-1:0] va, input logic [L*DW-1:0] vb,
                                         input bit sg, input bit ac, input bit la);
        res_t   r;
        bit     any_sat;
        longint x, y, p, s;
        r.val   = '0;
        any_sat = 0;
        for (int k = 0; k < L; k++) begin
            x = sg ? longint'($signed(va[k*DW +: DW])) : longint'(va[k*DW +: DW]);
            y = sg ? longint'($signed(vb[k*DW +: DW])) : longint'(vb[k*DW +: DW]);
            p = x * y;
            if (!ac) begin
                s = p & MASK;
                r.val[k*AW +: AW] = s[AW-1:0];
            end else begin
`ifdef MULT_ROW_PIPE_SAT_EN
                if (sg) begin
                    s = ((macc[k] >= HALF) ? macc[k] - (MASK + 1) : macc[k]) + p;
                    if (s > HALF - 1) begin s = HALF - 1; any_sat = 1; end
                    else if (s < -HALF) begin s = -HALF; any_sat = 1; end
                end else begin
                    s = macc[k] + p;
                    if (s > MASK) begin s = MASK; any_sat = 1; end
                end
                s = s & MASK;
`else
                s = (macc[k] + p) & MASK;
`endif
                if (la) begin
                    r.val[k*AW +: AW] = s[AW-1:0];
                    macc[k] = 0;
                end else begin
                    macc[k] = s;
                end
            end
        end
        if (!ac) begin
            r.sat = 1'b0;
            exp_q.push_back(r);
        end else if (la) begin
            r.sat = gsat | any_sat;
            gsat  = 0;
            exp_q.push_back(r);
        end else begin
            gsat = gsat | any_sat;
        end
    endfunction

    function automatic logic [L*DW-1:0] rnd_vec();
        logic [L*DW-1:0] v;
        for (int k = 0; k < L; k++) begin
            case ($urandom_range(0, 7))
                0:       v[k*DW +: DW] = 8'h80;
                1:       v[k*DW +: DW] = 8'h7F;
                2:       v[k*DW +: DW] = 8'hFF;
                default: v[k*DW +: DW] = DW'($urandom());
            endcase
        end
        return v;
    endfunction

    // Called at posedge+1; returns at posedge+1 after the accepting edge.
    task automatic send(input logic [L*DW-1:0] va, input logic [L*DW-1:0] vb,
                        input bit sg, input bit ac, input bit la);
        int n;
        bit ok;
        bus.in_valid  = 1'b1;
        bus.a         = va;
        bus.b         = vb;
        bus.is_signed = sg;
        bus.acc_en    = ac;
        bus.in_last   = la;
        ok = 0;
        n  = 0;
        while (!ok && n < 200) begin
            @(negedge clk);
            ok = bus.in_ready;
            @(posedge clk);
            #1;
            n++;
        end
        bus.in_valid = 1'b0;
        if (!ok) chk("send_timeout", bus.in_ready, 1'b1);
        else     model_accept(va, vb, sg, ac, la);
    endtask

    task automatic expect_out(input string tag, input logic [L*AW-1:0] v);
        int n;
        n = 0;
        @(negedge clk);
        while (!bus.out_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_valid"}, bus.out_valid, 1'b1);
        chk(tag, bus.out, v);
        @(posedge clk);
        #1;
    endtask

    task automatic expect_out2(input string tag, input logic [L*AW2-1:0] v, input logic s);
        int n;
        n = 0;
        @(negedge clk);
        while (!bus2.out_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_valid"}, bus2.out_valid, 1'b1);
        chk(tag, bus2.out, v);
        chk({tag, "_sat"}, bus2.out_sat, s);
        @(posedge clk);
        #1;
    endtask

    always @(posedge clk) begin
        if (rand_rdy) begin
            #1;
            bus.out_ready = ($urandom_range(0, 3) != 0);
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            chk("in_ready_rule", bus.in_ready, !bus.out_valid || bus.out_ready);
            if (bus.out_valid && bus.out_ready) begin
                if (exp_q.size() == 0) begin
                    chk("spurious_out_valid", bus.out_valid, 1'b0);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("out", bus.out, mon_e.val);
                    chk("out_sat", bus.out_sat, mon_e.sat);
                    n_out++;
                end
            end
        end
    end

    initial begin
        logic [L*DW-1:0] va, vb;
        logic [L*AW-1:0] ev;
        int n0;

        rst_n = 1'b0;  rand_rdy = 0;  gsat = 0;
        foreach (macc[k]) macc[k] = 0;
        bus.in_valid  = 0; bus.a  = '0; bus.b  = '0; bus.is_signed  = 0; bus.acc_en  = 0; bus.in_last  = 0;
        bus.out_ready = 1;
        bus2.in_valid = 0; bus2.a = '0; bus2.b = '0; bus2.is_signed = 0; bus2.acc_en = 0; bus2.in_last = 0;
        bus2.out_ready = 1;

        repeat (2) @(negedge clk);
        chk("rst_out_valid", bus.out_valid, 1'b0);
        chk("rst_out", bus.out, '0);
        chk("rst_out_sat", bus.out_sat, 1'b0);
        chk("rst_in_ready", bus.in_ready, 1'b1);
        chk("rst_out_valid2", bus2.out_valid, 1'b0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Unsigned 0xFF*0xFF with latency probe
        va = {L{8'hFF}};
        send(va, va, 0, 0, 0);
        @(negedge clk); chk("lat_edge1", bus.out_valid, 1'b0);
        @(negedge clk); chk("lat_edge2", bus.out_valid, 1'b0);
        @(negedge clk); chk("lat_edge3", bus.out_valid, 1'b1);
        chk("u_ff_ff", bus.out, {L{24'h00FE01}});
        @(posedge clk);
        #1;

        // 0x80 * 0x7F signed and unsigned
        va = {L{8'h80}};
        vb = {L{8'h7F}};
        send(va, vb, 1, 0, 0);
        expect_out("s_80_7f", {L{24'hFFC080}});
        send(va, vb, 0, 0, 0);
        expect_out("u_80_7f", {L{24'h003F80}});

        // Four-beat accumulation: lane k = 4 * (k*3)
        n0 = n_out;
        for (int k = 0; k < L; k++) begin
            va[k*DW +: DW] = DW'(k);
            vb[k*DW +: DW] = 8'd3;
            ev[k*AW +: AW] = AW'(12 * k);
        end
        for (int i = 0; i < 4; i++) send(va, vb, 0, 1, i == 3);
        expect_out("acc4", ev);
        repeat (4) @(posedge clk);
        #1;
        chk("acc4_count", n_out - n0, 1);

        // Backpressure mid-stream
        n0 = n_out;
        fork
            begin
                for (int i = 0; i < 6; i++) send(rnd_vec(), rnd_vec(), i[0], 0, 0);
            end
            begin
                repeat (4) @(posedge clk);
                #1;
                bus.out_ready = 1'b0;
                repeat (5) begin
                    @(negedge clk);
                    chk("bp_in_ready", bus.in_ready, 1'b0);
                    chk("bp_hold_valid", bus.out_valid, 1'b1);
                    @(posedge clk);
                end
                #1;
                bus.out_ready = 1'b1;
            end
        join
        repeat (8) @(posedge clk);
        #1;
        chk("bp_count", n_out - n0, 6);
        chk("bp_drained", exp_q.size(), 0);

        // Random beats, random gaps, random out_ready
        rand_rdy = 1;
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                @(posedge clk);
                #1;
            end
            send(rnd_vec(), rnd_vec(), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 $urandom_range(0, 2) == 0);
        end
        send(rnd_vec(), rnd_vec(), 1'($urandom_range(0, 1)), 1, 1);
        rand_rdy = 0;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        chk("rand_drained", exp_q.size(), 0);

        // Reset in the middle of an open group
        va = {L{8'd10}};
        vb = {L{8'd1}};
        send(va, vb, 0, 1, 0);
        send(va, vb, 0, 1, 0);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0;
        exp_q.delete();
        foreach (macc[k]) macc[k] = 0;
        gsat = 0;
        @(negedge clk);
        chk("midrst_out_valid", bus.out_valid, 1'b0);
        chk("midrst_out", bus.out, '0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("postrst_out_valid", bus.out_valid, 1'b0);
        @(posedge clk);
        #1;
        va = {L{8'd7}};
        send(va, vb, 0, 1, 1);
        expect_out("midrst_result", {L{24'd7}});

        // 16-bit accumulator overflow, then a fresh 1x1 group
        bus2.a = {L{8'hFF}}; bus2.b = {L{8'hFF}};
        bus2.is_signed = 0; bus2.acc_en = 1; bus2.in_last = 0; bus2.in_valid = 1;
        @(posedge clk); #1;
        bus2.in_last = 1;
        @(posedge clk); #1;
        bus2.in_valid = 0;
`ifdef MULT_ROW_PIPE_SAT_EN
        expect_out2("ovf", {L{16'hFFFF}}, 1'b1);
`else
        expect_out2("ovf", {L{16'hFC02}}, 1'b0);
`endif
        bus2.a = {L{8'h01}}; bus2.b = {L{8'h01}};
        bus2.acc_en = 1; bus2.in_last = 1; bus2.in_valid = 1;
        @(posedge clk); #1;
        bus2.in_valid = 0;
        expect_out2("ovf_next", {L{16'h0001}}, 1'b0);

        repeat (4) @(posedge clk);
        #1;
        chk("final_queue_empty", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
